// File: rtl/base_ademux_fifo.sv
// Buffered valid/ready demux/fork: {sel,data} beats queue in a FIFO and the head
// beat is offered to every selected way; it pops once all selected ways took it.

module base_ademux_fifo_way (
    input  logic clk,
    input  logic reset_n,
    input  logic head_v,
    input  logic head_sel,
    input  logic pop,
    input  logic o_r,
    output logic o_v,
    output logic take_ok
);
    logic done;

    assign o_v     = head_v & head_sel & ~done;
    // Way is satisfied if it was never selected, already took the head, or takes it now.
    assign take_ok = ~head_sel | done | o_r;

    always_ff @(posedge clk) begin
        if (!reset_n)
            done <= 1'b0;
        else if (pop)
            done <= 1'b0;
        else
            done <= done | (o_v & o_r);
    end
endmodule

module base_ademux_fifo #(
    parameter int ways  = 2,
    parameter int width = 1,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ways-1:0]  sel,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    output logic [ways-1:0]  o_v,
    input  logic [ways-1:0]  o_r,
    output logic [width-1:0] o_d
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    typedef struct packed {
        logic [ways-1:0]  sel;
        logic [width-1:0] data;
    } beat_t;

    beat_t          mem [depth];
    logic [aw-1:0]  wr_ptr, rd_ptr;
    logic [cw-1:0]  count;
    logic           head_v, push, pop;
    logic [ways-1:0] take_ok;
    beat_t          head;

    assign head   = mem[rd_ptr];
    // Gating with reset_n keeps outputs quiet during the reset cycle itself.
    assign head_v = reset_n & (count != '0);
    assign i_r    = reset_n & (count != cw'(depth));
    assign push   = i_v & i_r;
    assign pop    = head_v & (&take_ok);
    assign o_d    = head.data;

    for (genvar w = 0; w < ways; w++) begin : g_way
        base_ademux_fifo_way u_way (
            .clk      (clk),
            .reset_n  (reset_n),
            .head_v   (head_v),
            .head_sel (head.sel[w]),
            .pop      (pop),
            .o_r      (o_r[w]),
            .o_v      (o_v[w]),
            .take_ok  (take_ok[w])
        );
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{sel: sel, data: i_d};
    end

    // depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_base_ademux_fifo.sv
// Directed scenarios plus random traffic checked against a queue-based model.
module tb_base_ademux_fifo;
    localparam int WAYS = 2, WIDTH = 8, DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WAYS-1:0]  sel = '0, o_v, o_r = '0;
    logic             i_v = 1'b0, i_r;
    logic [WIDTH-1:0] i_d = '0, o_d;

    base_ademux_fifo #(.ways(WAYS), .width(WIDTH), .depth(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .i_v(i_v), .i_r(i_r),
        .i_d(i_d), .o_v(o_v), .o_r(o_r), .o_d(o_d)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    typedef struct packed {
        logic [WAYS-1:0]  sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            q[$];
    logic [WAYS-1:0]  m_done = '0;
    logic [WAYS-1:0]  last_ov;
    logic [WIDTH-1:0] last_od;
    logic             last_ir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic iv, input logic [WAYS-1:0] s,
                        input logic [WIDTH-1:0] d, input logic [WAYS-1:0] r);
        logic [WAYS-1:0] e_ov, xfer;
        logic            e_ir, pop;
        reset_n = rst; i_v = iv; sel = s; i_d = d; o_r = r;
        e_ir = rst && (q.size() < DEPTH);
        e_ov = (rst && q.size() != 0) ? (q[0].sel & ~m_done) : '0;
        @(negedge clk);
        last_ov = o_v; last_od = o_d; last_ir = i_r;
        chk("i_r", {31'd0, i_r}, {31'd0, e_ir});
        chk("o_v", {30'd0, o_v}, {30'd0, e_ov});
        if (e_ov != '0)
            chk("o_d", {24'd0, o_d}, {24'd0, q[0].data});
        xfer = e_ov & r;
        pop  = rst && q.size() != 0 && (((m_done | xfer) & q[0].sel) == q[0].sel);
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_done = '0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_done = '0;
            end else begin
                m_done = m_done | xfer;
            end
            if (iv && e_ir)
                q.push_back({s, d});
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;

        // reset held with i_v asserted
        step(0, 1, 2'b11, 8'h55, 2'b00);
        chk("rst_ir", {31'd0, last_ir}, 32'd0); chk("rst_ov", {30'd0, last_ov}, 32'd0);
        step(0, 1, 2'b11, 8'h55, 2'b00);
        chk("rst_ir2", {31'd0, last_ir}, 32'd0); chk("rst_ov2", {30'd0, last_ov}, 32'd0);
        step(1, 0, 2'b00, 8'h00, 2'b00);
        chk("rel_ir", {31'd0, last_ir}, 32'd1); chk("rel_ov", {30'd0, last_ov}, 32'd0);

        // unicast
        step(1, 1, 2'b01, 8'hA5, 2'b11);
        chk("uni_nobypass", {30'd0, last_ov}, 32'd0);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("uni_ov", {30'd0, last_ov}, 32'd1); chk("uni_od", {24'd0, last_od}, 32'hA5);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("uni_ov_end", {30'd0, last_ov}, 32'd0);

        // broadcast, ways accept in different cycles
        step(1, 1, 2'b11, 8'h3C, 2'b10);
        step(1, 0, 2'b00, 8'h00, 2'b10);
        chk("bc_ov1", {30'd0, last_ov}, 32'd3); chk("bc_od", {24'd0, last_od}, 32'h3C);
        step(1, 0, 2'b00, 8'h00, 2'b01);
        chk("bc_ov2", {30'd0, last_ov}, 32'd1);
        step(1, 0, 2'b00, 8'h00, 2'b01);
        chk("bc_ov3", {30'd0, last_ov}, 32'd0);

        // full
        step(1, 1, 2'b11, 8'h01, 2'b00);
        step(1, 1, 2'b11, 8'h02, 2'b00);
        step(1, 1, 2'b11, 8'h03, 2'b00);
        chk("full_ir", {31'd0, last_ir}, 32'd0);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("full_ir_pop", {31'd0, last_ir}, 32'd0); chk("drain_od1", {24'd0, last_od}, 32'h01);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("full_ir_after", {31'd0, last_ir}, 32'd1); chk("drain_od2", {24'd0, last_od}, 32'h02);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("drain_empty", {30'd0, last_ov}, 32'd0);

        // discard beat
        step(1, 1, 2'b00, 8'hFF, 2'b11);
        step(1, 1, 2'b10, 8'h11, 2'b11);
        chk("disc_ov0", {30'd0, last_ov}, 32'd0);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("disc_ov", {30'd0, last_ov}, 32'd2); chk("disc_od", {24'd0, last_od}, 32'h11);
        step(1, 0, 2'b00, 8'h00, 2'b11);
        chk("disc_end", {30'd0, last_ov}, 32'd0);

        // reset with partial accept pending
        step(1, 1, 2'b11, 8'hA1, 2'b00);
        step(1, 1, 2'b11, 8'hA2, 2'b00);
        step(1, 0, 2'b00, 8'h00, 2'b01);
        chk("mid_ov", {30'd0, last_ov}, 32'd3);
        step(0, 0, 2'b00, 8'h00, 2'b00);
        chk("mid_rst_ov", {30'd0, last_ov}, 32'd0);
        step(1, 1, 2'b01, 8'h77, 2'b01);
        chk("mid_after_ov", {30'd0, last_ov}, 32'd0); chk("mid_after_ir", {31'd0, last_ir}, 32'd1);
        step(1, 0, 2'b00, 8'h00, 2'b01);
        chk("mid_new_ov", {30'd0, last_ov}, 32'd1); chk("mid_new_od", {24'd0, last_od}, 32'h77);
        step(1, 0, 2'b00, 8'h00, 2'b00);

        // random traffic with varying ready pressure
        for (int n = 0; n < 3000; n++) begin
            logic [WAYS-1:0] r;
            int mode;
            mode = (n / 250) % 3;
            r = (mode == 0) ? WAYS'($urandom) :
                (mode == 1) ? ((($urandom_range(3) == 0) ? WAYS'($urandom) : '0)) : '1;
            step($urandom_range(99) != 0, $urandom_range(2) != 0, WAYS'($urandom),
                 WIDTH'($urandom), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
